// File: rtl/video_stream_sync_out.sv
// Raster timing generator with an input FIFO and a lock FSM that aligns the
// incoming AXI4-Stream video (tuser=SOF, tlast=EOL) to the timing origin.
module video_stream_sync_out #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HSYNC_POL  = 1'b0,
   parameter bit VSYNC_POL  = 1'b0,
   parameter int FIFO_DEPTH = 32
) (
   input  logic        s_axis_vid_aclk,
   input  logic        areset,
   input  logic [31:0] s_axis_vid_tdata,
   input  logic        s_axis_vid_tuser,
   input  logic        s_axis_vid_tlast,
   input  logic        s_axis_vid_tvalid,
   output logic        s_axis_vid_tready,
   input  logic        clear_status,
   output logic [23:0] vid_data,
   output logic        vid_de,
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic        locked,
   output logic        underflow_sticky,
   output logic [7:0]  err_count,
   output logic [1:0]  dbg_state
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int PW      = AW + 1;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [HW-1:0]  h_cnt_q, h_cnt_d;
   logic [VW-1:0]  v_cnt_q, v_cnt_d;
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [25:0]    fifo_mem_q [FIFO_DEPTH];
   logic [23:0]    vid_data_q, vid_data_d;
   logic           vid_de_q, vid_de_d;
   logic           vid_hsync_q, vid_hsync_d;
   logic           vid_vsync_q, vid_vsync_d;
   logic           underflow_q, underflow_d;
   logic [7:0]     err_count_q, err_count_d, err_base;
   logic           fifo_full, fifo_empty, push, pop;
   logic           active, frame_end, head_sof, head_eol;
   logic [23:0]    head_pix;
   logic           unused_tdata_hi;

   assign unused_tdata_hi = ^s_axis_vid_tdata[31:24];

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign s_axis_vid_tready = !fifo_full && !areset;
   assign push = s_axis_vid_tvalid && s_axis_vid_tready;

   // Head is read straight from storage; a word written this cycle is only
   // visible once wr_ptr_q has moved, so there is no push/pop bypass.
   assign {head_sof, head_eol, head_pix} = fifo_mem_q[rd_ptr_q[AW-1:0]];

   assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

   always_comb begin
      h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end
      vid_de_d    = active;
      vid_hsync_d = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HSYNC_POL : !HSYNC_POL;
      vid_vsync_d = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VSYNC_POL : !VSYNC_POL;
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      vid_data_d  = '0;
      underflow_d = clear_status ? 1'b0 : underflow_q;
      err_base    = clear_status ? 8'd0 : err_count_q;
      err_count_d = err_base;
      case (state_q)
         ST_HUNT: begin
            if (!fifo_empty) begin
               if (head_sof) state_d = ST_WAIT_SOF;
               else          pop     = 1'b1;
            end
         end
         ST_WAIT_SOF: begin
            if (frame_end) state_d = ST_LOCKED;
         end
         ST_LOCKED: begin
            if (active) begin
               if (fifo_empty) begin
                  underflow_d = 1'b1;
                  state_d     = ST_HUNT;
               end else begin
                  pop        = 1'b1;
                  vid_data_d = head_pix;
                  // A misaligned pixel is still shown; the stream is re-hunted after it.
                  if ((head_sof != ((h_cnt_q == '0) && (v_cnt_q == '0))) ||
                      (head_eol != (h_cnt_q == H_EOL))) begin
                     err_count_d = (err_base == 8'hFF) ? 8'hFF : err_base + 8'd1;
                     state_d     = ST_HUNT;
                  end
               end
            end
         end
         default: state_d = ST_HUNT;
      endcase
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_ff @(posedge s_axis_vid_aclk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_vid_tuser, s_axis_vid_tlast, s_axis_vid_tdata[23:0]};
      end
   end

   always_ff @(posedge s_axis_vid_aclk) begin
      if (areset) begin
         state_q     <= ST_HUNT;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         vid_data_q  <= '0;
         vid_de_q    <= 1'b0;
         vid_hsync_q <= !HSYNC_POL;
         vid_vsync_q <= !VSYNC_POL;
         underflow_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         vid_data_q  <= vid_data_d;
         vid_de_q    <= vid_de_d;
         vid_hsync_q <= vid_hsync_d;
         vid_vsync_q <= vid_vsync_d;
         underflow_q <= underflow_d;
         err_count_q <= err_count_d;
      end
   end

   assign vid_data         = vid_data_q;
   assign vid_de           = vid_de_q;
   assign vid_hsync        = vid_hsync_q;
   assign vid_vsync        = vid_vsync_q;
   assign locked           = (state_q == ST_LOCKED);
   assign underflow_sticky = underflow_q;
   assign err_count        = err_count_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_video_stream_sync_out.sv
// Directed bench for video_stream_sync_out on a shrunken 16x8 raster
// (8x4 active) with a 4-entry FIFO so whole frames run in a few hundred cycles.
module tb_video_stream_sync_out;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic        clk = 1'b0;
   logic        areset;
   logic [31:0] s_axis_vid_tdata;
   logic        s_axis_vid_tuser, s_axis_vid_tlast, s_axis_vid_tvalid;
   logic        s_axis_vid_tready;
   logic        clear_status;
   logic [23:0] vid_data;
   logic        vid_de, vid_hsync, vid_vsync, locked, underflow_sticky;
   logic [7:0]  err_count;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // Source model: next pixel to offer, plus the raster position shown on the outputs.
   int sx = 0, sy = 0, sfid = 0, short_fid = -1;
   bit src_en = 1'b0;
   int oh = 0, ov = 0;
   bit ovalid = 1'b0;

   video_stream_sync_out #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FIFO_DEPTH(4)
   ) dut (
      .s_axis_vid_aclk(clk), .areset(areset),
      .s_axis_vid_tdata(s_axis_vid_tdata), .s_axis_vid_tuser(s_axis_vid_tuser),
      .s_axis_vid_tlast(s_axis_vid_tlast), .s_axis_vid_tvalid(s_axis_vid_tvalid),
      .s_axis_vid_tready(s_axis_vid_tready), .clear_status(clear_status),
      .vid_data(vid_data), .vid_de(vid_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
      .locked(locked), .underflow_sticky(underflow_sticky), .err_count(err_count),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pix(input int x, input int y, input int f);
      return {8'hEE, 8'(f), 8'(y), 8'(x)};
   endfunction

   function automatic int line_len(input int y, input int f);
      return (f == short_fid && y == 2) ? HA - 1 : HA;
   endfunction

   task automatic drive_src();
      s_axis_vid_tvalid = src_en;
      s_axis_vid_tdata  = pix(sx, sy, sfid);
      s_axis_vid_tuser  = (sx == 0 && sy == 0);
      s_axis_vid_tlast  = (sx == line_len(sy, sfid) - 1);
   endtask

   task automatic cycle();
      logic hs, rs;
      hs = s_axis_vid_tvalid && s_axis_vid_tready;
      rs = areset;
      @(posedge clk);
      #1;
      if (rs) ovalid = 1'b0;
      else if (!ovalid) begin
         oh = 0; ov = 0; ovalid = 1'b1;
      end else begin
         oh = (oh == HT - 1) ? 0 : oh + 1;
         if (oh == 0) ov = (ov == VT - 1) ? 0 : ov + 1;
      end
      if (hs) begin
         if (sx == line_len(sy, sfid) - 1) begin
            sx = 0;
            if (sy == VA - 1) begin sy = 0; sfid++; end
            else sy++;
         end else sx++;
      end
      drive_src();
   endtask

   task automatic run_to(input int x, input int y);
      int n;
      n = 0;
      while (!(ovalid && oh == x && ov == y) && n < 400) begin
         cycle();
         n++;
      end
      if (n >= 400) begin
         n_err++;
         $error("FAIL run_to(%0d,%0d): position not reached in %0d cycles", x, y, n);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   initial begin
      int de_cnt, hs_cnt, vs_cnt, first_hs, bp_cnt, ux, uy, ufid, lf;
      logic [31:0] sum_obs, sum_exp;

      // Reset state
      areset = 1'b1; clear_status = 1'b0; src_en = 1'b0;
      drive_src();
      repeat (3) cycle();
      chk("rst_de", vid_de, 0);
      chk("rst_data", vid_data, 0);
      chk("rst_hsync", vid_hsync, 1);
      chk("rst_vsync", vid_vsync, 1);
      chk("rst_locked", locked, 0);
      chk("rst_sticky", underflow_sticky, 0);
      chk("rst_err", err_count, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_tready", s_axis_vid_tready, 0);
      areset = 1'b0;
      #1;
      chk("rel_tready", s_axis_vid_tready, 1);

      // Raster timing, measured from DUT signals
      run_to(0, 1);
      de_cnt = 0; hs_cnt = 0; first_hs = -1;
      for (int i = 0; i < HT; i++) begin
         if (vid_de) de_cnt++;
         if (!vid_hsync) begin
            hs_cnt++;
            if (first_hs < 0) first_hs = i;
         end
         cycle();
      end
      chk("line_de_cycles", de_cnt, 8);
      chk("line_hsync_cycles", hs_cnt, 3);
      chk("hsync_start_h", first_hs, 10);
      run_to(0, 0);
      de_cnt = 0; vs_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
         if (vid_de) de_cnt++;
         if (!vid_vsync) vs_cnt++;
         cycle();
      end
      chk("frame_de_cycles", de_cnt, 32);
      chk("frame_vsync_cycles", vs_cnt, 32);
      run_to(7, 3);  chk("de_last_active", vid_de, 1);
      run_to(8, 3);  chk("de_after_active", vid_de, 0);
      run_to(9, 3);  chk("hsync_before", vid_hsync, 1);
      run_to(12, 3); chk("hsync_last", vid_hsync, 0);
      run_to(13, 3); chk("hsync_after", vid_hsync, 1);
      run_to(0, 4);  chk("de_vblank", vid_de, 0);
      run_to(15, 4); chk("vsync_before", vid_vsync, 1);
      run_to(0, 5);  chk("vsync_first", vid_vsync, 0);
      run_to(15, 6); chk("vsync_last", vid_vsync, 0);
      run_to(0, 7);  chk("vsync_after", vid_vsync, 1);
      chk("unlocked_no_stream", locked, 0);

      // Lock: stream starts mid-raster-frame with SOF
      run_to(0, 2);
      src_en = 1'b1; sx = 0; sy = 0; sfid = 0;
      drive_src();
      run_to(14, 7);
      chk("wait_sof_state", dbg_state, 1);
      chk("tready_full", s_axis_vid_tready, 0);
      run_to(0, 0);
      chk("lock_locked", locked, 1);
      chk("lock_state", dbg_state, 2);
      chk("lock_first_pix", vid_data, pix(0, 0, 0) & 32'hFFFFFF);
      run_to(7, 0); chk("pix_7_0", vid_data, pix(7, 0, 0) & 32'hFFFFFF);
      run_to(8, 0); chk("blank_data", vid_data, 0);
      run_to(3, 2); chk("pix_3_2", vid_data, pix(3, 2, 0) & 32'hFFFFFF);
      run_to(7, 3); chk("pix_7_3", vid_data, pix(7, 3, 0) & 32'hFFFFFF);
      chk("lock_err", err_count, 0);

      // Backpressure: checksum a whole frame while the FIFO is kept full
      run_to(0, 0);
      sum_obs = 0; de_cnt = 0; bp_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
         if (vid_de) begin sum_obs += {8'h00, vid_data}; de_cnt++; end
         if (s_axis_vid_tvalid && !s_axis_vid_tready) bp_cnt++;
         cycle();
      end
      sum_exp = 0;
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++) sum_exp += pix(x, y, 1) & 32'hFFFFFF;
      chk("frame1_checksum", sum_obs, sum_exp);
      chk("frame1_pixels", de_cnt, 32);
      chk("backpressure_seen", (bp_cnt > 0), 1);
      chk("frame1_locked", locked, 1);

      // Underflow: stall the stream a few pixels into line 1
      run_to(1, 1);
      src_en = 1'b0;
      drive_src();
      ux = sx; uy = sy; ufid = sfid;
      if (ux > 0) begin
         run_to(ux - 1, uy);
         chk("pre_underflow_pix", vid_data, pix(ux - 1, uy, ufid) & 32'hFFFFFF);
      end
      run_to(ux, uy);
      chk("underflow_data", vid_data, 0);
      chk("underflow_de", vid_de, 1);
      chk("underflow_sticky", underflow_sticky, 1);
      chk("underflow_state", dbg_state, 0);
      chk("underflow_err", err_count, 0);
      src_en = 1'b1;
      drive_src();
      run_to(0, 0);
      chk("relock_uf", locked, 1);
      chk("relock_uf_pix", vid_data, pix(0, 0, ufid + 1) & 32'hFFFFFF);
      chk("sticky_held", underflow_sticky, 1);
      clear_status = 1'b1;
      cycle();
      clear_status = 1'b0;
      chk("sticky_cleared", underflow_sticky, 0);

      // Short line: line 2 of the next frame ends one pixel early
      lf = sfid + 1;
      short_fid = lf;
      run_to(7, 3);
      run_to(5, 2);
      chk("short_pre_pix", vid_data, pix(5, 2, lf) & 32'hFFFFFF);
      run_to(6, 2);
      chk("short_err_pix", vid_data, pix(6, 2, lf) & 32'hFFFFFF);
      chk("short_err_count", err_count, 1);
      chk("short_state", dbg_state, 0);
      run_to(0, 0);
      chk("relock_short", locked, 1);
      chk("relock_short_pix", vid_data, pix(0, 0, lf + 1) & 32'hFFFFFF);
      chk("err_held", err_count, 1);
      clear_status = 1'b1;
      cycle();
      clear_status = 1'b0;
      chk("err_cleared", err_count, 0);

      // Reset mid-frame while locked
      run_to(3, 2);
      chk("prereset_pix", vid_data, pix(3, 2, lf + 1) & 32'hFFFFFF);
      areset = 1'b1; src_en = 1'b0;
      drive_src();
      cycle();
      chk("mid_rst_de", vid_de, 0);
      chk("mid_rst_data", vid_data, 0);
      chk("mid_rst_hsync", vid_hsync, 1);
      chk("mid_rst_vsync", vid_vsync, 1);
      chk("mid_rst_locked", locked, 0);
      chk("mid_rst_state", dbg_state, 0);
      chk("mid_rst_tready", s_axis_vid_tready, 0);
      areset = 1'b0;
      #1;
      chk("mid_rel_tready", s_axis_vid_tready, 1);
      cycle();
      chk("restart_de", vid_de, 1);
      chk("restart_data", vid_data, 0);
      chk("restart_locked", locked, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
